pingpong_ctrl: RTL and testbench

- Game-control state machine for the two-player FPGA ping-pong game.
- Sits directly upstream of the CS decoder and drives the decoder's 3-bit CS code: ball position, point-scored pulses, and game-over.
- Consumes debounced one-cycle button pulses and a game-speed STEP tick.
- Keeps both players' scores and the winner flag.

---
 rtl/pingpong_pkg.sv | 52 +++++
 rtl/pingpong_score.sv | 42 ++++
 rtl/pingpong_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pingpong_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong game controller: CS codes,
// ball direction constants, internal state enum and state-to-CS mapping.
package pingpong_pkg;

  // CS codes presented to the downstream decoder
  localparam logic [2:0] CS_IDLE      = 3'b000;
  localparam logic [2:0] CS_R1        = 3'b001;
  localparam logic [2:0] CS_R2        = 3'b110;
  localparam logic [2:0] CS_L2        = 3'b111;
  localparam logic [2:0] CS_L1        = 3'b010;
  localparam logic [2:0] CS_POINT_A   = 3'b011;
  localparam logic [2:0] CS_POINT_B   = 3'b100;
  localparam logic [2:0] CS_GAME_OVER = 3'b101;

  // Ball direction
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    SERVE_A,
    SERVE_B,
    POS_R1,
    POS_R2,
    POS_L2,
    POS_L1,
    POINT_A,
    POINT_B,
    GAME_OVER
  } state_e;

  // Serve states share the LED code of the end position they serve from
  function automatic logic [2:0] cs_of(input state_e s);
    logic [2:0] code;
    code = CS_IDLE;
    case (s)
      IDLE:      code = CS_IDLE;
      SERVE_A:   code = CS_R1;
      SERVE_B:   code = CS_L1;
      POS_R1:    code = CS_R1;
      POS_R2:    code = CS_R2;
      POS_L2:    code = CS_L2;
      POS_L1:    code = CS_L1;
      POINT_A:   code = CS_POINT_A;
      POINT_B:   code = CS_POINT_B;
      GAME_OVER: code = CS_GAME_OVER;
      default:   code = CS_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pingpong_score.sv
// Saturating score counter with clear and a "reached winning score" flag.
module pingpong_score
  import pingpong_pkg::*;
#(
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 7
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               inc,
  input  logic               clr,
  output logic [SCORE_W-1:0] score,
  output logic               reached
);

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  logic [SCORE_W-1:0] count_q, count_d;

  // Next count: clear wins over increment; increment stops at the winning score
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q < WIN)) begin
      count_d = count_q + SCORE_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign score   = count_q;
  assign reached = (count_q == WIN);

endmodule

// File: rtl/pingpong_ctrl.sv
// Ping-pong game controller: ball movement, hits, misses, fouls, scoring
// and game-over, producing a registered CS code for the LED decoder.
module pingpong_ctrl
  import pingpong_pkg::*;
#(
  parameter int WIN_SCORE = 7,
  parameter int SCORE_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STEP,
  input  logic               HITA,
  input  logic               HITB,
  output logic [2:0]         CS,
  output logic [SCORE_W-1:0] SCOREA,
  output logic [SCORE_W-1:0] SCOREB,
  output logic               WINNER
);

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic       armed_q, armed_d;
  logic       winner_q, winner_d;
  logic [2:0] cs_q;
  logic       clr_scores;
  logic       reached_a, reached_b;
  logic       ball_in_a, ball_in_b;

  // The ball is arriving at a player's end (a press there is a return)
  assign ball_in_a = (dir_q == DIR_RIGHT);
  assign ball_in_b = (dir_q == DIR_LEFT);

  // Next-state logic: movement, hits, misses, fouls and point resolution
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    armed_d    = armed_q;
    winner_d   = winner_q;
    clr_scores = 1'b0;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (START) begin
          state_d    = SERVE_A;
          dir_d      = DIR_LEFT;
          armed_d    = 1'b0;
          winner_d   = 1'b0;
          clr_scores = 1'b1;
        end
      end
      SERVE_A: begin
        if (armed_q && STEP) begin
          state_d = POS_R2;
          armed_d = 1'b0;
        end else if (HITA) begin
          armed_d = 1'b1;
        end
      end
      SERVE_B: begin
        if (armed_q && STEP) begin
          state_d = POS_L2;
          armed_d = 1'b0;
        end else if (HITB) begin
          armed_d = 1'b1;
        end
      end
      POS_R1: begin
        if (ball_in_a && HITA) begin
          dir_d = DIR_LEFT;
        end
        if (STEP) begin
          state_d = (ball_in_a && !HITA) ? POINT_B : POS_R2;
        end
      end
      POS_R2: begin
        if (ball_in_a && HITA) begin
          state_d = POINT_B;
        end else if (STEP) begin
          state_d = (dir_q == DIR_RIGHT) ? POS_R1 : POS_L2;
        end
      end
      POS_L2: begin
        if (ball_in_b && HITB) begin
          state_d = POINT_A;
        end else if (STEP) begin
          state_d = (dir_q == DIR_RIGHT) ? POS_R2 : POS_L1;
        end
      end
      POS_L1: begin
        if (ball_in_b && HITB) begin
          dir_d = DIR_RIGHT;
        end
        if (STEP) begin
          state_d = (ball_in_b && !HITB) ? POINT_A : POS_L2;
        end
      end
      POINT_A: begin
        if (reached_a) begin
          state_d  = GAME_OVER;
          winner_d = 1'b0;
        end else begin
          state_d = SERVE_B;
          dir_d   = DIR_RIGHT;
          armed_d = 1'b0;
        end
      end
      POINT_B: begin
        if (reached_b) begin
          state_d  = GAME_OVER;
          winner_d = 1'b1;
        end else begin
          state_d = SERVE_A;
          dir_d   = DIR_LEFT;
          armed_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, direction, serve-arm, winner and registered CS code
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      dir_q    <= DIR_LEFT;
      armed_q  <= 1'b0;
      winner_q <= 1'b0;
      cs_q     <= CS_IDLE;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      armed_q  <= armed_d;
      winner_q <= winner_d;
      cs_q     <= cs_of(state_d);
    end
  end

  // Scores bump on the same edge that enters the point state
  pingpong_score #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_score_a (
    .clk     (CLK),
    .srst    (RST),
    .inc     (state_d == POINT_A),
    .clr     (clr_scores),
    .score   (SCOREA),
    .reached (reached_a)
  );

  pingpong_score #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_score_b (
    .clk     (CLK),
    .srst    (RST),
    .inc     (state_d == POINT_B),
    .clr     (clr_scores),
    .score   (SCOREB),
    .reached (reached_b)
  );

  assign CS     = cs_q;
  assign WINNER = winner_q;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl: a vector table for the rally basics,
// then hand-written sequences for game-over, restart and mid-rally reset.
module tb_pingpong_ctrl;

  logic       CLK = 1'b0;
  logic       RST, START, STEP, HITA, HITB;
  logic [2:0] CS;
  logic [3:0] SCOREA, SCOREB;
  logic       WINNER;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       start;
    logic       step;
    logic       hita;
    logic       hitb;
    logic [2:0] cs;
    logic [3:0] sa;
    logic [3:0] sb;
    logic       w;
  } vec_t;

  vec_t vecs[$];

  pingpong_ctrl #(.WIN_SCORE(7), .SCORE_W(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .STEP   (STEP),
    .HITA   (HITA),
    .HITB   (HITB),
    .CS     (CS),
    .SCOREA (SCOREA),
    .SCOREB (SCOREB),
    .WINNER (WINNER)
  );

  always #5 CLK = ~CLK;

  // Append one vector: inputs for one cycle, outputs expected after the edge
  task automatic add(input logic r, input logic s, input logic st, input logic ha,
                     input logic hb, input logic [2:0] c, input logic [3:0] a,
                     input logic [3:0] b, input logic w);
    vec_t v;
    v.rst = r; v.start = s; v.step = st; v.hita = ha; v.hitb = hb;
    v.cs = c; v.sa = a; v.sb = b; v.w = w;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, sample outputs 1ns after the rising edge
  task automatic cycle(input logic r, input logic s, input logic st,
                       input logic ha, input logic hb);
    @(negedge CLK);
    RST = r; START = s; STEP = st; HITA = ha; HITB = hb;
    @(posedge CLK);
    #1;
    RST = 1'b0; START = 1'b0; STEP = 1'b0; HITA = 1'b0; HITB = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] c, input logic [3:0] a,
                         input logic [3:0] b, input logic w);
    chk({tag, " cs"}, int'(CS), int'(c));
    chk({tag, " scorea"}, int'(SCOREA), int'(a));
    chk({tag, " scoreb"}, int'(SCOREB), int'(b));
    chk({tag, " winner"}, int'(WINNER), int'(w));
    $display("%s: cs=%b a=%0d b=%0d w=%0d", tag, CS, SCOREA, SCOREB, WINNER);
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; STEP = 1'b0; HITA = 1'b0; HITB = 1'b0;

    //   rst st  stp ha  hb   cs      A  B  W
    add(1, 0, 0, 0, 0, 3'b000, 0, 0, 0);  // reset
    add(0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3'b000, 0, 0, 0);  // idle ignores STEP
    add(0, 0, 0, 1, 0, 3'b000, 0, 0, 0);  // idle ignores HITA
    add(0, 1, 0, 0, 0, 3'b001, 0, 0, 0);  // START -> SERVE_A
    add(0, 0, 1, 0, 0, 3'b001, 0, 0, 0);  // unarmed STEP ignored
    add(0, 0, 0, 0, 1, 3'b001, 0, 0, 0);  // HITB ignored
    add(0, 0, 0, 1, 0, 3'b001, 0, 0, 0);  // arm serve
    add(0, 0, 1, 0, 0, 3'b110, 0, 0, 0);  // R2
    add(0, 0, 1, 0, 0, 3'b111, 0, 0, 0);  // L2
    add(0, 0, 1, 0, 0, 3'b010, 0, 0, 0);  // L1 arriving
    add(0, 0, 0, 0, 1, 3'b010, 0, 0, 0);  // B returns
    add(0, 0, 1, 0, 0, 3'b111, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3'b110, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3'b001, 0, 0, 0);  // R1 arriving
    add(0, 0, 1, 1, 0, 3'b110, 0, 0, 0);  // hit+step same cycle
    add(0, 0, 1, 0, 0, 3'b111, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3'b010, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3'b011, 1, 0, 0);  // B misses -> POINT_A
    add(0, 0, 0, 0, 0, 3'b010, 1, 0, 0);  // SERVE_B
    add(0, 0, 1, 0, 0, 3'b010, 1, 0, 0);  // unarmed STEP ignored
    add(0, 0, 0, 0, 1, 3'b010, 1, 0, 0);  // arm
    add(0, 0, 1, 0, 0, 3'b111, 1, 0, 0);  // L2 moving right
    add(0, 0, 1, 0, 0, 3'b110, 1, 0, 0);  // R2 moving right
    add(0, 0, 0, 1, 0, 3'b100, 1, 1, 0);  // A foul -> POINT_B
    add(0, 0, 0, 0, 0, 3'b001, 1, 1, 0);  // SERVE_A
    add(0, 1, 0, 0, 0, 3'b001, 1, 1, 0);  // START mid-game ignored
    add(0, 0, 0, 1, 0, 3'b001, 1, 1, 0);
    add(0, 0, 1, 0, 0, 3'b110, 1, 1, 0);
    add(0, 0, 0, 1, 0, 3'b110, 1, 1, 0);  // HITA at R2 moving left ignored
    add(0, 0, 1, 0, 0, 3'b111, 1, 1, 0);
    add(0, 0, 0, 0, 1, 3'b011, 2, 1, 0);  // B foul at L2 -> POINT_A
    add(0, 0, 0, 0, 0, 3'b010, 2, 1, 0);  // SERVE_B

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].start, vecs[i].step, vecs[i].hita, vecs[i].hitb);
      chk_all($sformatf("vec%0d", i), vecs[i].cs, vecs[i].sa, vecs[i].sb, vecs[i].w);
    end

    // From SERVE_B: A fouls at R2, B reaches 2
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk_all("foul_b2", 3'b100, 2, 2, 0);
    cycle(0, 0, 0, 0, 0);
    chk_all("serve_a_b2", 3'b001, 2, 2, 0);

    // Rallies from SERVE_A ending in an A foul, until B has 7
    for (int b = 3; b <= 7; b++) begin
      cycle(0, 0, 0, 1, 0);  // arm
      cycle(0, 0, 1, 0, 0);  // R2
      cycle(0, 0, 1, 0, 0);  // L2
      cycle(0, 0, 1, 0, 0);  // L1
      cycle(0, 0, 0, 0, 1);  // B returns
      cycle(0, 0, 1, 0, 0);  // L2
      cycle(0, 0, 1, 0, 0);  // R2 moving right
      cycle(0, 0, 0, 1, 0);  // foul
      chk_all($sformatf("rally_b%0d point", b), 3'b100, 2, 4'(b), 0);
      cycle(0, 0, 0, 0, 0);
      if (b < 7) chk_all($sformatf("rally_b%0d serve", b), 3'b001, 2, 4'(b), 0);
      else       chk_all("game_over", 3'b101, 2, 7, 1);
    end

    // Game over holds against play inputs
    cycle(0, 0, 1, 1, 1);
    cycle(0, 0, 1, 0, 0);
    chk_all("game_over_hold", 3'b101, 2, 7, 1);

    // Restart clears scores and winner
    cycle(0, 1, 0, 0, 0);
    chk_all("restart", 3'b001, 0, 0, 0);

    // Mid-rally reset with other inputs active
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0);
    chk_all("rally_r2", 3'b110, 0, 0, 0);
    cycle(1, 1, 1, 1, 1);
    chk_all("mid_rst", 3'b000, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk_all("post_rst_idle", 3'b000, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
